// File: rtl/fifo_stream_rd.sv
// Read-side sequencer between a fifo read port and a valid/ready consumer.
// Absorbs the one-cycle RAM read latency in a 2-entry skid buffer.
module fifo_stream_rd #(
  parameter int unsigned DLEN = 8
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            o_ren,
  input  logic [DLEN-1:0] i_rdata,
  input  logic            i_rempty,
  input  logic            i_runderflow,
  output logic            o_valid,
  output logic [DLEN-1:0] o_data,
  input  logic            i_ready,
  input  logic            i_flush,
  output logic            o_err,
  output logic [1:0]      o_level
);

  logic [DLEN-1:0] head_q, head_d;
  logic [DLEN-1:0] tail_q, tail_d;
  logic [1:0]      level_q, level_d;
  logic            inflight_q, inflight_d;
  logic            err_q, err_d;
  logic            run_q;
  logic            issue_empty_q, issue_empty_d;

  logic            pop;
  logic            capture;
  logic [2:0]      occupancy;
  logic [1:0]      level_after_pop;
  logic [DLEN-1:0] head_after_pop;
  logic [DLEN-1:0] tail_after_pop;

  assign pop       = o_valid & i_ready;
  assign capture   = inflight_q & ~i_flush;
  assign occupancy = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};

  // run_q keeps o_ren low until the first clock edge after reset release.
  assign o_ren = run_q & ~i_rempty & ~i_flush & (occupancy < 3'd2);

  always_comb begin
    level_after_pop = level_q - {1'b0, pop};
    head_after_pop  = pop ? tail_q : head_q;
    tail_after_pop  = pop ? '0 : tail_q;

    head_d        = head_after_pop;
    tail_d        = tail_after_pop;
    level_d       = level_after_pop;
    inflight_d    = o_ren;
    issue_empty_d = o_ren & i_rempty;
    err_d         = err_q | i_runderflow | (inflight_q & issue_empty_q);

    if (i_flush) begin
      head_d     = '0;
      tail_d     = '0;
      level_d    = 2'd0;
      inflight_d = 1'b0;
    end else if (capture) begin
      // First free slot after the same-cycle pop.
      if (level_after_pop == 2'd0) begin
        head_d = i_rdata;
      end else begin
        tail_d = i_rdata;
      end
      level_d = level_after_pop + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q        <= '0;
      tail_q        <= '0;
      level_q       <= 2'd0;
      inflight_q    <= 1'b0;
      err_q         <= 1'b0;
      run_q         <= 1'b0;
      issue_empty_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      level_q       <= level_d;
      inflight_q    <= inflight_d;
      err_q         <= err_d;
      run_q         <= 1'b1;
      issue_empty_q <= issue_empty_d;
    end
  end

  assign o_data  = head_q;
  assign o_level = level_q;
  assign o_valid = (level_q != 2'd0);
  assign o_err   = err_q;

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Bench for fifo_stream_rd: a queue-based fifo and stream model with directed
// scenarios followed by randomized traffic.
module tb_fifo_stream_rd;

  localparam int unsigned DLEN = 8;

  logic            clk;
  logic            rstn;
  logic            o_ren;
  logic [DLEN-1:0] i_rdata;
  logic            i_rempty;
  logic            i_runderflow;
  logic            o_valid;
  logic [DLEN-1:0] o_data;
  logic            i_ready;
  logic            i_flush;
  logic            o_err;
  logic [1:0]      o_level;

  fifo_stream_rd #(.DLEN(DLEN)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .o_ren        (o_ren),
    .i_rdata      (i_rdata),
    .i_rempty     (i_rempty),
    .i_runderflow (i_runderflow),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .i_flush      (i_flush),
    .o_err        (o_err),
    .o_level      (o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference state: fifo contents, words held by the stream, word in flight.
  logic [DLEN-1:0] fifo_q[$];
  logic [DLEN-1:0] sb_q[$];
  logic [DLEN-1:0] delivered[$];
  logic [DLEN-1:0] rd_word;
  int              inflight_m;
  logic            err_m;
  logic            run_m;
  int unsigned     n_ren;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ren"},   32'(o_ren),   32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_data"},  32'(o_data),  32'd0);
    check({tag, "_level"}, 32'(o_level), 32'd0);
    check({tag, "_err"},   32'(o_err),   32'd0);
  endtask

  task automatic apply_reset(input int unsigned hold);
    @(negedge clk);
    rstn         = 1'b0;
    i_flush      = 1'b0;
    i_runderflow = 1'b0;
    i_ready      = 1'b1;
    i_rempty     = (fifo_q.size() == 0);
    #1;
    check_idle_outputs("rst_assert");
    sb_q.delete();
    inflight_m = 0;
    err_m      = 1'b0;
    run_m      = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    i_rempty = (fifo_q.size() == 0);
    #1;
    check_idle_outputs("rst_hold");
    rstn = 1'b1;
    // The edge after release only arms the sequencer; issue may start after it.
    run_m = 1'b1;
  endtask

  task automatic cycle(input logic rdy, input logic fl, input logic uf);
    int   lvl;
    int   pop;
    logic exp_ren;
    logic ren_s;
    @(negedge clk);
    i_ready      = rdy;
    i_flush      = fl;
    i_runderflow = uf;
    i_rempty     = (fifo_q.size() == 0);
    i_rdata      = rd_word;
    #1;
    lvl     = sb_q.size();
    pop     = (lvl != 0 && rdy) ? 1 : 0;
    exp_ren = run_m && (fifo_q.size() != 0) && !fl && ((lvl + inflight_m - pop) < 2);
    check("ren",   32'(o_ren),   32'(exp_ren));
    check("valid", 32'(o_valid), 32'(lvl != 0));
    check("level", 32'(o_level), 32'(lvl));
    check("err",   32'(o_err),   32'(err_m));
    if (lvl != 0) check("data", 32'(o_data), 32'(sb_q[0]));
    ren_s = o_ren;
    if (ren_s) n_ren++;
    if (o_valid && rdy) delivered.push_back(o_data);
    @(posedge clk);
    if (pop != 0) void'(sb_q.pop_front());
    if (fl) sb_q.delete();
    else if (inflight_m != 0) sb_q.push_back(rd_word);
    inflight_m = ren_s ? 1 : 0;
    if (ren_s && fifo_q.size() != 0) rd_word = fifo_q.pop_front();
    err_m = err_m | uf;
  endtask

  task automatic drain();
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    delivered.delete();
    n_ren = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rstn         = 1'b1;
    i_rdata      = '0;
    i_rempty     = 1'b1;
    i_runderflow = 1'b0;
    i_ready      = 1'b0;
    i_flush      = 1'b0;
    rd_word      = '0;
    inflight_m   = 0;
    err_m        = 1'b0;
    run_m        = 1'b0;
    n_ren        = 0;

    // Reset with a non-empty fifo, then stream three words.
    fifo_q = '{8'h11, 8'h22, 8'h33};
    apply_reset(3);
    n_ren = 0;
    delivered.delete();
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    check("t1_ren_count", n_ren, 3);
    check("t1_delivered", delivered.size(), 3);
    if (delivered.size() == 3) begin
      check("t1_w0", 32'(delivered[0]), 32'h11);
      check("t1_w1", 32'(delivered[1]), 32'h22);
      check("t1_w2", 32'(delivered[2]), 32'h33);
    end
    drain();

    // Backpressure: only two words get pulled, then a gap-free release.
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    check("t2_ren_count", n_ren, 2);
    #1;
    check("t2_level", 32'(o_level), 32'd2);
    check("t2_hold",  32'(o_data),  32'h11);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    check("t2_delivered", delivered.size(), 5);
    for (int i = 0; i < 5 && i < delivered.size(); i++) begin
      check("t2_word", 32'(delivered[i]), 32'((i + 1) * 8'h11));
    end
    drain();

    // Steady streaming: level 1 with a read in flight stays at 1.
    fifo_q = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6};
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    #1;
    check("t3_level", 32'(o_level), 32'd1);
    check("t3_data",  32'(o_data),  32'ha3);
    drain();

    // Flush while a read is in flight: that word is dropped.
    fifo_q = '{8'hb0, 8'hb1, 8'hb2};
    cycle(1'b0, 1'b0, 1'b0);
    check("t4_issued", n_ren, 1);
    cycle(1'b0, 1'b1, 1'b0);
    #1;
    check("t4_valid", 32'(o_valid), 32'd0);
    check("t4_level", 32'(o_level), 32'd0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    check("t4_count", delivered.size(), 2);
    if (delivered.size() != 0) check("t4_first", 32'(delivered[0]), 32'hb1);
    drain();

    // Empty boundary: a single word.
    fifo_q = '{8'h5a};
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    check("t5_ren_count", n_ren, 1);
    check("t5_delivered", delivered.size(), 1);
    check("t5_err", 32'(o_err), 32'd0);
    drain();

    // Underflow: sticky through flush, cleared by reset.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    #1;
    check("t6_err_sticky", 32'(o_err), 32'd1);
    apply_reset(2);
    #1;
    check("t6_err_clear", 32'(o_err), 32'd0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 40 && fifo_q.size() < 16) begin
        fifo_q.push_back(DLEN'($urandom_range(0, 255)));
      end
      if (c == 300) apply_reset(1);
      cycle($urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
